// File: rtl/alu_seq_exec.sv
// Sequential ALU execution unit: single-cycle logic/add/sub, bit-serial shifts,
// valid/ready on both request and result sides.
module alu_seq_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;

  localparam logic [1:0] SH_LL = OP_SLL[1:0];
  localparam logic [1:0] SH_RL = OP_SRL[1:0];

  state_t           state;
  logic [1:0]       sh_q;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   cnt;

  logic [SHW-1:0]   shamt;
  logic             legal;
  logic             is_shift;
  logic             accept;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] sh_nxt;

  assign shamt    = b[SHW-1:0];
  assign legal    = ~op[3];
  assign is_shift = (op == OP_SLL) | (op == OP_SRL) | (op == OP_SRA);
  assign accept   = in_valid & in_ready;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Shift ops with a zero amount fall through to the default and pass a.
  always_comb begin
    alu_y = a;
    unique case (1'b1)
      op == OP_ADD: alu_y = a + b;
      op == OP_SUB: alu_y = a + ~b + WIDTH'(1);
      op == OP_AND: alu_y = a & b;
      op == OP_OR:  alu_y = a | b;
      op == OP_XOR: alu_y = a ^ b;
      default:      alu_y = a;
    endcase
  end

  always_comb begin
    sh_nxt = work;
    unique case (1'b1)
      sh_q == SH_LL: sh_nxt = {work[WIDTH-2:0], 1'b0};
      sh_q == SH_RL: sh_nxt = {1'b0, work[WIDTH-1:1]};
      default:       sh_nxt = {work[WIDTH-1], work[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sh_q      <= '0;
      work      <= '0;
      cnt       <= '0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sh_q    <= op[1:0];
            illegal <= ~legal;
            if (!legal) begin
              result    <= '0;
              zero      <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (is_shift && shamt != '0) begin
              work  <= a;
              cnt   <= shamt;
              state <= SHIFT;
            end else begin
              result    <= alu_y;
              zero      <= (alu_y == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          work <= sh_nxt;
          cnt  <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            result    <= sh_nxt;
            zero      <= (sh_nxt == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Scoreboard bench for alu_seq_exec: directed spec cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_alu_seq_exec;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;
  logic         busy;

  alu_seq_exec #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .zero(zero),
    .illegal(illegal),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         ill;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   seen = 0;
  bit   rand_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic z,
                              input logic ill, input int lat);
    exp_t e;
    e.res = r;
    e.z   = z;
    e.ill = ill;
    e.cyc = lat;
    return e;
  endfunction

  // cyc field holds edges after the accept edge until out_valid is seen
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t e;
    int   n;
    n     = int'(y[4:0]);
    e.ill = 1'b0;
    e.cyc = 0;
    case (o)
      4'd0:    e.res = x + y;
      4'd1:    e.res = x - y;
      4'd2:    e.res = x & y;
      4'd3:    e.res = x | y;
      4'd4:    e.res = x ^ y;
      4'd5:    e.res = x << n;
      4'd6:    e.res = x >> n;
      4'd7:    e.res = $signed(x) >>> n;
      default: begin
        e.res = '0;
        e.ill = 1'b1;
      end
    endcase
    if (o >= 4'd5 && o <= 4'd7) e.cyc = n;
    e.z = (e.res == '0);
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input exp_t e);
    exp_t t;
    bit   ok;
    t = e;
    ok = 0;
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end else begin
      t.cyc = t.cyc + cyc;
      q.push_back(t);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending, required 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: out_valid 1 with result %h, required 0", result);
      end else begin
        if (!seen) begin
          chk("latency_cycle", W'(cyc), W'(q[0].cyc));
          seen = 1;
        end
        chk("result", result, q[0].res);
        chk("zero", W'(zero), W'(q[0].z));
        chk("illegal", W'(illegal), W'(q[0].ill));
        chk("in_ready_in_done", W'(in_ready), '0);
        if (out_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    logic [3:0]   o;
    logic [W-1:0] x;
    logic [W-1:0] y;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = '0;
    a = '0;
    b = '0;
    #1;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_result", result, '0);
    chk("rst_busy", W'(busy), '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(4'b0001, 32'd5, 32'd5, mk(32'h0, 1'b1, 1'b0, 0));
    issue(4'b0001, 32'd0, 32'd1, mk(32'hFFFF_FFFF, 1'b0, 1'b0, 0));
    issue(4'b0000, 32'hFFFF_FFFF, 32'd1, mk(32'h0, 1'b1, 1'b0, 0));
    issue(4'b0111, 32'h8000_0000, 32'd4, mk(32'hF800_0000, 1'b0, 1'b0, 4));
    issue(4'b0110, 32'h8000_0000, 32'd4, mk(32'h0800_0000, 1'b0, 1'b0, 4));
    issue(4'b0101, 32'd1, 32'd31, mk(32'h8000_0000, 1'b0, 1'b0, 31));
    issue(4'b0101, 32'h8000_0000, 32'h20, mk(32'h8000_0000, 1'b0, 1'b0, 0));
    drain();

    out_ready = 1'b0;
    issue(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'h0FF0_0FF0, 1'b0, 1'b0, 0));
    in_valid = 1'b1;
    op = 4'b0000;
    a = 32'd1;
    b = 32'd1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", W'(in_ready), '0);
      chk("bp_out_valid", W'(out_valid), W'(1));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_back_to_idle", W'(in_ready), W'(1));
    chk("bp_valid_dropped", W'(out_valid), '0);

    issue(4'b1111, 32'd123, 32'd456, mk(32'h0, 1'b1, 1'b1, 0));
    issue(4'b0010, 32'hFF, 32'h0F, mk(32'h0F, 1'b0, 1'b0, 0));
    drain();

    issue(4'b0101, 32'h1234_5678, 32'd20, mk(32'h0, 1'b0, 1'b0, 20));
    repeat (9) @(posedge clk);
    #3;
    chk("mid_busy_before", W'(busy), W'(1));
    rst = 1'b1;
    q.delete();
    seen = 0;
    #1;
    chk("mid_rst_busy", W'(busy), '0);
    chk("mid_rst_in_ready", W'(in_ready), W'(1));
    chk("mid_rst_out_valid", W'(out_valid), '0);
    chk("mid_rst_result", result, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (25) begin
      @(negedge clk);
      chk("post_rst_quiet", W'(out_valid), '0);
    end
    @(posedge clk);
    #1;
    issue(4'b0000, 32'd3, 32'd4, mk(32'd7, 1'b0, 1'b0, 0));
    drain();

    rand_ready = 1;
    repeat (300) begin
      if ($urandom_range(0, 9) == 0) o = 4'($urandom_range(8, 15));
      else o = 4'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 7) == 0) y[4:0] = 5'd0;
      issue(o, x, y, model(o, x, y));
    end
    rand_ready = 0;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
